// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw pins toward the conditioner, clean levels and strobes back.
// master = the side owning the pins and consuming the outputs, slave = btn_conditioner.
interface btn_conditioner_if #(
  parameter int unsigned N_BTN = 2
) ();

  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_toggle;
  logic [N_BTN-1:0] btn_long;

  modport master (
    output btn,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_toggle,
    input  btn_long
  );

  modport slave (
    input  btn,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_toggle,
    output btn_long
  );

endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce, press/release strobes, toggle.
// Optional long-press strobe built only when BTN_LONG_PRESS_EN is defined.
module btn_conditioner #(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned LONG_CYCLES     = 27000000
) (
  input  logic          clk,
  input  logic          rst,
  btn_conditioner_if.slave bus
);

  localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic        IDLE_PIN = (ACTIVE_LOW != 0);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1 || N_BTN < 1) begin : g_bad_cfg
    $error("btn_conditioner: need N_BTN >= 1, DEBOUNCE_CYCLES >= 2, LONG_CYCLES >= 1");
  end

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] pressed;
  logic [N_BTN-1:0] flip;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic [N_BTN-1:0] toggle_q;
  logic [CNT_W-1:0] db_cnt [N_BTN];

  // Metastability guard; stages rest at the released pin value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= {N_BTN{IDLE_PIN}};
      sync2 <= {N_BTN{IDLE_PIN}};
    end else begin
      sync1 <= bus.btn;
      sync2 <= sync1;
    end
  end

  assign pressed = IDLE_PIN ? ~sync2 : sync2;

  // A channel flips once it has disagreed with its level for the full window.
  always_comb begin
    flip = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      flip[i] = (pressed[i] != level_q[i]) && (db_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        if ((pressed[i] == level_q[i]) || flip[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Strobes land in the same cycle the new level first shows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
    end else begin
      level_q   <= level_q ^ flip;
      press_q   <= flip & pressed;
      release_q <= flip & ~pressed;
      toggle_q  <= toggle_q ^ (flip & pressed);
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_toggle  = toggle_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PREV = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt [N_BTN];
  logic [N_BTN-1:0]  long_q;

  // Saturating hold timer; the strobe fires only on the step into saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        hold_cnt[i] <= '0;
      end
      long_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (!level_q[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != HOLD_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
        end
        long_q[i] <= level_q[i] && (hold_cnt[i] == HOLD_PREV);
      end
    end
  end

  assign bus.btn_long = long_q;
`else
  assign bus.btn_long = '0;
`endif

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-side conditioner for the board's push-buttons, mirroring the LED/flip-flop output path.
- Per button: synchronises the raw active-low pin, debounces it, and emits a clean level, one-cycle press/release strobes and a toggle state (T flip-flop).
- Sits between the board button pins and downstream sequential logic in TOP, so that logic is clocked by `clk` with enables instead of by raw buttons.

Parameters:
- N_BTN, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 270000, clocks the synchronised input must differ stably from the current level before the level flips (10 ms at 27 MHz); minimum 2.
- ACTIVE_LOW, 1, 1 means the pin reads 0 when pressed (input is inverted internally); 0 means active-high pin.
- LONG_CYCLES, 27000000, hold time in clocks for a long-press strobe (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- btn  input  N_BTN  raw button pins, asynchronous to clk.
- btn_level  output  N_BTN  debounced state, 1 = pressed.
- btn_press  output  N_BTN  one-clk strobe on debounced 0->1.
- btn_release  output  N_BTN  one-clk strobe on debounced 1->0.
- btn_toggle  output  N_BTN  flips on every debounced press.
- btn_long  output  N_BTN  one-clk long-press strobe (see Optional Feature).

Behaviour:
- All channels are identical and fully independent; no interaction between bits.
- Reset: asynchronous assert, release is sampled on clk.
  - Synchroniser stages are set to the released value (1 if ACTIVE_LOW, else 0).
  - btn_level, btn_press, btn_release, btn_toggle, btn_long, debounce counter and hold counter all go to 0.
- Synchroniser: two flops per channel. The value after stage 2 is inverted if ACTIVE_LOW, giving s (1 = pressed).
- Debounce counter: width $clog2(DEBOUNCE_CYCLES).
  - If s == btn_level, the counter clears to 0.
  - If s != btn_level and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If s != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level <= s, counter clears, and in the same edge btn_press <= s or btn_release <= ~s.
- Strobes are registered: btn_press/btn_release are high for exactly the one cycle in which btn_level first shows the new value. Otherwise they are 0.
- Latency: with the pin held stable, btn_level changes on rising edge number DEBOUNCE_CYCLES+2, counting the first edge that samples the new pin value as edge 1.
- Glitches: any bounce back to equality before the count completes clears the counter. A pulse shorter than DEBOUNCE_CYCLES clocks (post-sync) never changes btn_level and produces no strobe.
- btn_toggle inverts on the same edge that btn_press is set; release has no effect on it.
- Counter never wraps: it cannot exceed DEBOUNCE_CYCLES-1.
- Reset mid-count or mid-press: everything returns to reset values. A button still held when reset releases is re-debounced from scratch and yields a fresh btn_press.
- Hold counter: counts only while btn_level == 1, saturates at LONG_CYCLES, and clears when btn_level == 0.

Optional Feature:
- Macro BTN_LONG_PRESS_EN.
- When defined:
  - The hold counter is built, width $clog2(LONG_CYCLES+1).
  - btn_long pulses for one clk on the edge the hold counter reaches LONG_CYCLES.
  - At most one btn_long per press; the counter saturates, so no repeat.
  - Release clears the counter.
- When undefined:
  - No hold counter logic is built.
  - btn_long stays present and is tied to 0, so the instantiation is identical either way.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1, N_BTN=2):
- Reset: assert rst with btn=2'b00 (both pressed) -> all outputs 0 immediately, without waiting for a clk edge. After release, btn_level[1:0]=2'b11 on the 6th edge, with btn_press=2'b11 for exactly that cycle.
- Clean press: btn[0] 1->0 and held -> btn_level[0]=1 and btn_press[0]=1 on edge 6, btn_press[0]=0 on edge 7, btn_toggle[0]=1. Release held -> btn_release[0] one-cycle pulse 6 edges later; btn_toggle[0] stays 1.
- Bounce: btn[0] low 3 clks, high 1 clk, low 2 clks, then high -> btn_level[0] and all strobes stay 0 throughout.
- Independence/simultaneity: btn[0] pressed 2 clks before btn[1], both held -> press strobes on different edges, 2 apart. A second press of btn[0] returns btn_toggle[0] to 0 while btn_toggle[1]=1.
- Mid-count reset: press btn[1], assert rst at edge 4 for 1 clk, keep pressed -> no strobe before reset. btn_press[1] fires 6 edges after rst deasserts.
- Long press, BTN_LONG_PRESS_EN defined: hold btn[0] 30 clks -> single btn_long[0] pulse 10 edges after btn_level[0] rose. Without the macro -> btn_long stays 2'b00.
